trng_conditioner: RTL and testbench

- Downstream consumer of the ring-oscillator TRNG output.
- Synchronises the free-running async `rnd` bit into the `clk` domain and decimates it to one raw sample every SAMPLE_DIV cycles.
- Removes bias with a von Neumann corrector, packs the corrected bits into WORD_W-bit words and presents them on a valid/ready stream.
- Runs a repetition-count health test on raw samples and latches a sticky failure flag.

---
 rtl/trng_pkg.sv | 20 ++
 rtl/trng_conditioner_sync_ff.sv | 25 ++
 rtl/trng_conditioner.sv | 198 +++++++++++++++++++
 tb/tb_trng_conditioner.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trng_pkg.sv
// Shared defaults and width helper for the TRNG conditioner.
package trng_pkg;

   // Default configuration of the conditioner.
   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_SAMPLE_DIV  = 4;
   localparam int DEF_WORD_W      = 8;
   localparam int DEF_REP_LIMIT   = 32;

   // Bits needed to hold values 0..n-1, never less than one bit.
   function automatic int cnt_w(input int n);
      int w;
      w = $clog2(n);
      if (w < 1) begin
         w = 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/trng_conditioner_sync_ff.sv
// N-stage single-bit synchroniser with synchronous active-high reset.
// The first stage is the only flop that sees the asynchronous input.
module sync_ff #(
   parameter int N = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [N-1:0] stages;

   // Shift the input through the chain; the oldest stage is the output.
   always_ff @(posedge clk) begin
      if (rst) begin
         stages <= '0;
      end else begin
         stages <= {stages[N-2:0], d};
      end
   end

   assign q = stages[N-1];

endmodule

// File: rtl/trng_conditioner.sv
// TRNG conditioner: synchronises the ring-oscillator bit, decimates it,
// removes bias with a von Neumann corrector, packs corrected bits into
// words and runs a repetition-count health test on the raw samples.
//
// Output stream: a word moves when out_valid and out_ready are both high
// on a rising edge. While out_valid is high and out_ready is low, out_data
// and out_valid hold. A full word waiting in the packer reloads the output
// register in the same cycle as a transfer, so words can go back to back.
module trng_conditioner
   import trng_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int SAMPLE_DIV  = DEF_SAMPLE_DIV,
   parameter int WORD_W      = DEF_WORD_W,
   parameter int REP_LIMIT   = DEF_REP_LIMIT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rnd_in,
   input  logic              en,
   output logic [WORD_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              health_fail
);

   localparam int DIV_W = cnt_w(SAMPLE_DIV);
   localparam int BIT_W = cnt_w(WORD_W + 1);
   localparam int REP_W = cnt_w(REP_LIMIT + 1);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_FULL = BIT_W'(WORD_W);
   localparam logic [REP_W-1:0] REP_MAX  = REP_W'(REP_LIMIT);

   // Raw sample source (last synchroniser stage).
   logic raw;

   // Decimation.
   logic [DIV_W-1:0] div_cnt;
   logic             tick;

   // Von Neumann pair buffer and its corrected output.
   logic pair_full;
   logic pair_a;
   logic vn_valid;
   logic vn_bit;

   // Packer.
   logic [WORD_W-1:0] shift;
   logic [BIT_W-1:0]  bit_cnt;
   logic              word_full;
   logic              load;
   logic              accept_bit;
   logic              xfer;

   // Health test.
   logic [REP_W-1:0] rep_cnt;
   logic [REP_W-1:0] rep_next;
   logic             prev_sample;
   logic             have_prev;
   logic             trip;
   logic             kill;

   sync_ff #(
      .N(SYNC_STAGES)
   ) u_sync (
      .clk(clk),
      .rst(rst),
      .d  (rnd_in),
      .q  (raw)
   );

   // ------------------------------------------------------------------
   // Decimation: one raw sample every SAMPLE_DIV enabled cycles.
   // ------------------------------------------------------------------
   assign tick = en & (div_cnt == DIV_LAST);

   // Count enabled cycles, wrapping at the tick; disabled holds at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt <= '0;
      end else if (!en || tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   // ------------------------------------------------------------------
   // Von Neumann corrector: 10 -> 1, 01 -> 0, 00/11 -> nothing.
   // ------------------------------------------------------------------
   assign vn_valid = tick & pair_full & (pair_a != raw);
   assign vn_bit   = pair_a;

   // Hold the first bit of a pair; any second bit empties the buffer.
   always_ff @(posedge clk) begin
      if (rst) begin
         pair_full <= 1'b0;
         pair_a    <= 1'b0;
      end else if (!en) begin
         pair_full <= 1'b0;
      end else if (tick) begin
         if (!pair_full) begin
            pair_a    <= raw;
            pair_full <= 1'b1;
         end else begin
            pair_full <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Repetition-count health test on raw samples.
   // ------------------------------------------------------------------

   // Next run length: restart at 1 on a new value, saturate at the limit.
   always_comb begin
      rep_next = rep_cnt;
      if (tick) begin
         if (have_prev && (raw == prev_sample)) begin
            if (rep_cnt == REP_MAX) begin
               rep_next = REP_MAX;
            end else begin
               rep_next = rep_cnt + REP_W'(1);
            end
         end else begin
            rep_next = REP_W'(1);
         end
      end
   end

   assign trip = tick & (rep_next == REP_MAX);
   assign kill = health_fail | trip;

   // Track the run of identical samples and latch a sticky failure.
   always_ff @(posedge clk) begin
      if (rst) begin
         rep_cnt     <= '0;
         prev_sample <= 1'b0;
         have_prev   <= 1'b0;
         health_fail <= 1'b0;
      end else begin
         if (tick) begin
            rep_cnt     <= rep_next;
            prev_sample <= raw;
            have_prev   <= 1'b1;
         end
         if (trip) begin
            health_fail <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Packer and output register.
   // ------------------------------------------------------------------
   assign xfer      = out_valid & out_ready;
   assign word_full = (bit_cnt == BIT_FULL);
   // A full word moves to the output when the slot is free or being emptied.
   assign load      = word_full & (~out_valid | xfer);
   // A corrected bit is kept when there is room, including room freed by load.
   assign accept_bit = vn_valid & (~word_full | load);

   // Shift corrected bits in at the LSB; a load restarts the word.
   always_ff @(posedge clk) begin
      if (rst || kill) begin
         shift   <= '0;
         bit_cnt <= '0;
      end else if (accept_bit) begin
         if (load) begin
            shift   <= {{(WORD_W-1){1'b0}}, vn_bit};
            bit_cnt <= BIT_W'(1);
         end else begin
            shift   <= {shift[WORD_W-2:0], vn_bit};
            bit_cnt <= bit_cnt + BIT_W'(1);
         end
      end else if (load) begin
         shift   <= '0;
         bit_cnt <= '0;
      end
   end

   // Output slot: load a finished word, drop it on transfer or failure.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_data  <= '0;
         out_valid <= 1'b0;
      end else if (kill) begin
         out_valid <= 1'b0;
      end else if (load) begin
         out_data  <= shift;
         out_valid <= 1'b1;
      end else if (xfer) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_trng_conditioner.sv
// Directed bench for trng_conditioner: two instances (SAMPLE_DIV 1 and 4)
// share one stimulus, a cycle model predicts their outputs, and a few
// hand-computed words pin the expected streams.
module tb_trng_conditioner;

   localparam int WW  = 8;
   localparam int LIM = 32;
   localparam int SS  = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rnd_in = 1'b0;
   logic en = 1'b0;
   logic out_ready = 1'b0;

   logic [WW-1:0] data_a, data_b;
   logic valid_a, valid_b, fail_a, fail_b;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   // Transfer logs: word and cycle of every accepted word.
   logic [WW-1:0] xq_a[$];
   logic [WW-1:0] xq_b[$];
   int xc_a[$];

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   trng_conditioner #(
      .SYNC_STAGES(SS), .SAMPLE_DIV(1), .WORD_W(WW), .REP_LIMIT(LIM)
   ) dut_a (
      .clk(clk), .rst(rst), .rnd_in(rnd_in), .en(en),
      .out_data(data_a), .out_valid(valid_a), .out_ready(out_ready),
      .health_fail(fail_a)
   );

   trng_conditioner #(
      .SYNC_STAGES(SS), .SAMPLE_DIV(4), .WORD_W(WW), .REP_LIMIT(LIM)
   ) dut_b (
      .clk(clk), .rst(rst), .rnd_in(rnd_in), .en(en),
      .out_data(data_b), .out_valid(valid_b), .out_ready(out_ready),
      .health_fail(fail_b)
   );

   // ---------------- checker ----------------
   task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // ---------------- model ----------------
   int div_of[2] = '{1, 4};
   logic hist_q[$];
   int phase[2];
   int pair_n[2];
   logic pair_a[2];
   int bits_n[2];
   logic [WW-1:0] bits_v[2];
   int run[2];
   logic last_s[2];
   bit have_last[2];
   logic m_valid[2];
   logic [WW-1:0] m_data[2];
   logic m_fail[2];
   bit armed = 1'b0;

   // Advance the predicted state on every rising edge from the driven inputs.
   always @(posedge clk) begin
      logic raw;
      bit tick, cb_ok, trip, xfer, load;
      logic cb;
      cyc++;
      if (rst) begin
         hist_q.delete();
         armed = 1'b1;
         for (int k = 0; k < 2; k++) begin
            phase[k] = 0; pair_n[k] = 0; pair_a[k] = 1'b0;
            bits_n[k] = 0; bits_v[k] = '0;
            run[k] = 0; last_s[k] = 1'b0; have_last[k] = 1'b0;
            m_valid[k] = 1'b0; m_data[k] = '0; m_fail[k] = 1'b0;
         end
      end else begin
         // The sample seen now is rnd_in as it was SS edges ago.
         raw = (hist_q.size() >= SS) ? hist_q[hist_q.size() - SS] : 1'b0;
         hist_q.push_back(rnd_in);
         if (hist_q.size() > SS) hist_q.pop_front();
         for (int k = 0; k < 2; k++) begin
            tick = en && (phase[k] == div_of[k] - 1);
            phase[k] = en ? (phase[k] + 1) % div_of[k] : 0;
            cb_ok = 1'b0;
            cb = 1'b0;
            if (!en) begin
               pair_n[k] = 0;
            end else if (tick) begin
               if (pair_n[k] == 0) begin
                  pair_a[k] = raw;
                  pair_n[k] = 1;
               end else begin
                  if (pair_a[k] != raw) begin
                     cb_ok = 1'b1;
                     cb = pair_a[k];
                  end
                  pair_n[k] = 0;
               end
            end
            trip = 1'b0;
            if (tick) begin
               if (have_last[k] && raw == last_s[k]) run[k] = (run[k] < LIM) ? run[k] + 1 : LIM;
               else run[k] = 1;
               last_s[k] = raw;
               have_last[k] = 1'b1;
               trip = (run[k] == LIM);
            end
            xfer = m_valid[k] && out_ready;
            if (m_fail[k] || trip) begin
               m_fail[k] = 1'b1;
               m_valid[k] = 1'b0;
               bits_n[k] = 0;
               bits_v[k] = '0;
            end else begin
               load = (bits_n[k] == WW) && (!m_valid[k] || xfer);
               if (load) begin
                  m_data[k] = bits_v[k];
                  m_valid[k] = 1'b1;
                  bits_n[k] = 0;
                  bits_v[k] = '0;
               end else if (xfer) begin
                  m_valid[k] = 1'b0;
               end
               if (cb_ok && bits_n[k] < WW) begin
                  bits_v[k] = {bits_v[k][WW-2:0], cb};
                  bits_n[k]++;
               end
            end
         end
      end
   end

   // Compare both instances against the model on every falling edge.
   always @(negedge clk) begin
      if (armed) begin
         cmp("a.valid", valid_a, m_valid[0]);
         cmp("a.fail", fail_a, m_fail[0]);
         if (m_valid[0]) cmp("a.data", data_a, m_data[0]);
         cmp("b.valid", valid_b, m_valid[1]);
         cmp("b.fail", fail_b, m_fail[1]);
         if (m_valid[1]) cmp("b.data", data_b, m_data[1]);
         if (valid_a === 1'b1 && out_ready === 1'b1) begin
            xq_a.push_back(data_a);
            xc_a.push_back(cyc);
         end
         if (valid_b === 1'b1 && out_ready === 1'b1) xq_b.push_back(data_b);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      en = 1'b0;
      repeat (n) step();
   endtask

   // Drive n samples (v MSB first) so that each reaches a tick of a
   // SAMPLE_DIV=div instance; two priming cycles fill the synchroniser.
   task automatic send(input logic [63:0] v, input int n, input int div);
      int idx;
      for (int j = -2; j < n * div; j++) begin
         idx = (j + 2) / div;
         if (idx > n - 1) idx = n - 1;
         en = (j >= 0);
         rnd_in = v[n - 1 - idx];
         step();
      end
      en = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1;
      step();
      step();
      @(negedge clk);
      cmp("reset.valid_a", valid_a, 1'b0);
      cmp("reset.fail_a", fail_a, 1'b0);
      cmp("reset.data_a", data_a, 8'h00);
      cmp("reset.valid_b", valid_b, 1'b0);
      rst = 1'b0;

      // Reset mid-word: partial bits 1,0,1 must not reach the first word.
      out_ready = 1'b1;
      send(64'h26, 6, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      cmp("t1.valid_after_rst", valid_a, 1'b0);
      cmp("t1.fail_after_rst", fail_a, 1'b0);
      xq_a.delete();
      xc_a.delete();
      send(64'h9999, 16, 1);
      idle(4);
      cmp("t1.count", xq_a.size(), 1);
      cmp("t1.word", (xq_a.size() > 0) ? xq_a[0] : 8'hxx, 8'hAA);

      // Correction with interleaved 00/11 pairs.
      xq_a.delete();
      xc_a.delete();
      send(64'h8787_4B4B, 32, 1);
      idle(4);
      cmp("t2.count", xq_a.size(), 1);
      cmp("t2.word", (xq_a.size() > 0) ? xq_a[0] : 8'hxx, 8'hA5);

      // Backpressure: A5 held, 3C waits in the packer, FF dropped.
      out_ready = 1'b0;
      xq_a.delete();
      xc_a.delete();
      send(64'h9966_5AA5_AAAA, 48, 1);
      idle(3);
      @(negedge clk);
      cmp("t3.held_valid", valid_a, 1'b1);
      cmp("t3.held_data", data_a, 8'hA5);
      out_ready = 1'b1;
      step();
      step();
      out_ready = 1'b0;
      idle(3);
      @(negedge clk);
      cmp("t3.count", xq_a.size(), 2);
      cmp("t3.word0", (xq_a.size() > 0) ? xq_a[0] : 8'hxx, 8'hA5);
      cmp("t3.word1", (xq_a.size() > 1) ? xq_a[1] : 8'hxx, 8'h3C);
      cmp("t3.no_bubble", (xc_a.size() > 1) ? xc_a[1] - xc_a[0] : 0, 1);
      cmp("t3.drained", valid_a, 1'b0);

      // Health: pending FF, then 32 identical raw samples.
      xq_a.delete();
      send(64'hAAAA, 16, 1);
      idle(2);
      send(64'h7FFF_FFFF, 31, 1);
      @(negedge clk);
      cmp("t4.fail_at_31", fail_a, 1'b0);
      cmp("t4.valid_at_31", valid_a, 1'b1);
      cmp("t4.data_at_31", data_a, 8'hFF);
      send(64'h1, 1, 1);
      @(negedge clk);
      cmp("t4.fail_at_32", fail_a, 1'b1);
      cmp("t4.valid_at_32", valid_a, 1'b0);
      out_ready = 1'b1;
      xq_a.delete();
      send(64'h9999, 16, 1);
      idle(4);
      cmp("t4.no_words", xq_a.size(), 0);
      cmp("t4.sticky", fail_a, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      cmp("t4.fail_cleared_a", fail_a, 1'b0);
      cmp("t4.fail_cleared_b", fail_b, 1'b0);

      // Decimation by 4 and partial pair discarded when en drops.
      out_ready = 1'b1;
      xq_b.delete();
      send(64'h1, 1, 4);
      idle(2);
      send(64'h6699, 16, 4);
      idle(6);
      cmp("t5.count", xq_b.size(), 1);
      cmp("t5.word", (xq_b.size() > 0) ? xq_b[0] : 8'hxx, 8'h5A);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Bound the run in case the stimulus ever stalls.
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
